// File: rtl/square_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : square_adder_ctrl
// Description : Sequencer for the square_adder energy datapath. It runs a
//               detection pass: optionally accumulate N samples of
//               re^2+im^2 as a noise reference, clear the adder, accumulate N
//               samples as signal energy, then flag the signal as present
//               when signal >= noise + (thres << THRES_SHIFT). The sum is
//               saturated to 2^30-1.
//               Samples arrive on a valid/ready handshake. The adder is driven
//               by a clock enable (sa_en) and a one-cycle clear (sa_aclr).
// Config      : SQ_CTRL_NOISE_EN defined -> full noise + signal run.
//               Undefined -> the noise phase is skipped and noise reads 0.
// Ports       : clk, aclr_n (async active-low reset)
//               start, thres[11:0]        run request, threshold (latched)
//               sample_valid/sample_ready handshake, datar/datai samples
//               sa_datar/sa_datai/sa_en/sa_aclr -> square_adder, sa_sum <-
//               noise/signal[29:0], busy, done (pulse), comp_signal (result)
// Revision    : 1.0 - initial release
// ============================================================================
module square_adder_ctrl #(
  parameter int N           = 16,  // samples per accumulation phase (>= 1)
  parameter int ADDER_LAT   = 2,   // sa_en sample -> visible on sa_sum
  parameter int THRES_SHIFT = 8    // left shift applied to thres
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        start,
  input  logic        sample_valid,
  input  logic [7:0]  datar,
  input  logic [7:0]  datai,
  output logic        sample_ready,
  input  logic [11:0] thres,
  output logic [7:0]  sa_datar,
  output logic [7:0]  sa_datai,
  output logic        sa_en,
  output logic        sa_aclr,
  input  logic [29:0] sa_sum,
  output logic [29:0] noise,
  output logic [29:0] signal,
  output logic        busy,
  output logic        done,
  output logic        comp_signal
);

  // One counter serves both the sample count (ACC) and the drain wait.
  localparam int c_cnt_max = (N > ADDER_LAT + 1) ? N : ADDER_LAT + 1;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_acc_last   = c_cnt_w'(N - 1);
  localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(ADDER_LAT);
  localparam logic [29:0]        c_sum_max    = 30'h3FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR_N   = 3'd1,
    S_ACC_N   = 3'd2,
    S_DRAIN_N = 3'd3,
    S_CLR_S   = 3'd4,
    S_ACC_S   = 3'd5,
    S_DRAIN_S = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [11:0]          r_thres;
  logic [29:0]          r_signal;
  logic                 r_comp;
  logic                 r_sa_en;
  logic [7:0]           r_sa_datar;
  logic [7:0]           r_sa_datai;

  logic                 w_accept;
  logic                 w_acc_last;
  logic                 w_drain_last;
  logic [29:0]          w_noise_val;
  logic [30:0]          w_thr;
  logic [30:0]          w_sum;
  logic [29:0]          w_limit;

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    sa_aclr      = 1'b0;
    sample_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
`ifdef SQ_CTRL_NOISE_EN
          w_next = S_CLR_N;
`else
          w_next = S_CLR_S;
`endif
        end
      end
      S_CLR_N: begin
        sa_aclr = 1'b1;
        w_next  = S_ACC_N;
      end
      S_ACC_N: begin
        sample_ready = 1'b1;
        if (sample_valid && w_acc_last) w_next = S_DRAIN_N;
      end
      S_DRAIN_N: begin
        if (w_drain_last) w_next = S_CLR_S;
      end
      S_CLR_S: begin
        sa_aclr = 1'b1;
        w_next  = S_ACC_S;
      end
      S_ACC_S: begin
        sample_ready = 1'b1;
        if (sample_valid && w_acc_last) w_next = S_DRAIN_S;
      end
      S_DRAIN_S: begin
        if (w_drain_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_accept     = sample_ready & sample_valid;
  assign w_acc_last   = (r_cnt == c_acc_last);
  assign w_drain_last = (r_cnt == c_drain_last);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Sample / drain counter. Cleared in the CLR states and wrapped to 0 on the
  // last accept so the drain wait starts from 0 without an extra state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_ACC_N, S_ACC_S: begin
          if (w_accept) r_cnt <= w_acc_last ? '0 : r_cnt + 1'b1;
        end
        S_DRAIN_N, S_DRAIN_S: begin
          r_cnt <= w_drain_last ? '0 : r_cnt + 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sample register toward the adder: one sa_en pulse per accepted sample,
  // one cycle after the accept.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_sa_en    <= 1'b0;
      r_sa_datar <= '0;
      r_sa_datai <= '0;
    end else begin
      r_sa_en <= w_accept;
      if (w_accept) begin
        r_sa_datar <= datar;
        r_sa_datai <= datai;
      end
    end
  end

  assign sa_en    = r_sa_en;
  assign sa_datar = r_sa_datar;
  assign sa_datai = r_sa_datai;

  // --------------------------------------------------------------------------
  // Noise capture (only in the two-phase build)
  // --------------------------------------------------------------------------
`ifdef SQ_CTRL_NOISE_EN
  logic [29:0] r_noise;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_noise <= '0;
    end else if (r_state == S_DRAIN_N && w_drain_last) begin
      r_noise <= sa_sum;
    end
  end

  assign w_noise_val = r_noise;
`else
  assign w_noise_val = '0;
`endif

  assign noise = w_noise_val;

  // --------------------------------------------------------------------------
  // Comparison limit: noise + (thres << THRES_SHIFT), saturated to 2^30-1.
  // The 31-bit threshold is exact for THRES_SHIFT <= 19.
  // --------------------------------------------------------------------------
  assign w_thr   = 31'(r_thres) << THRES_SHIFT;
  assign w_sum   = {1'b0, w_noise_val} + w_thr;
  assign w_limit = w_sum[30] ? c_sum_max : w_sum[29:0];

  // Signal and result are written on the same edge (DRAIN_S -> DONE), so the
  // comparison uses sa_sum directly rather than the not-yet-updated r_signal.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_thres  <= '0;
      r_signal <= '0;
      r_comp   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_thres <= thres;
        r_comp  <= 1'b0;
      end
      if (r_state == S_DRAIN_S && w_drain_last) begin
        r_signal <= sa_sum;
        r_comp   <= (sa_sum >= w_limit);
      end
    end
  end

  assign signal      = r_signal;
  assign comp_signal = r_comp;

endmodule
`default_nettype wire
